nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that processes one 4-bit nibble per clock, from LSB to MSB.
- Holds the carry in a register between nibbles.
- Gives wide operand additions a small, fixed per-cycle adder cost.
- Sits between the operand source and the result consumer, using a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of 4 and at least 4; any other value is a configuration error.
- NIB, WIDTH/4, derived nibble count. Local, not overridable.

Ports:
- clk    input   1      single clock, all state updates on rising edge
- rst_n  input   1      asynchronous, active-low reset
- start  input   1      request; sampled on a rising edge only while busy=0
- a      input   WIDTH  addend, captured when start is accepted
- b      input   WIDTH  addend, captured when start is accepted
- cin    input   1      carry into nibble 0, captured when start is accepted
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse: result valid
- sum    output  WIDTH  registered result
- cout   output  1      registered carry out of the top nibble

Behaviour:
- Reset: rst_n low forces state IDLE immediately (asynchronous).
  - Operand, carry and count registers clear to 0.
  - busy=0, done=0, sum=0, cout=0.
- State IDLE: busy=0, done=0.
  - start=1 at an edge: capture a, b and cin into internal registers, set nibble count k=0, go to RUN.
- State RUN: busy=1.
  - Each edge computes nibble k through a combinational 4-bit ripple slice of full adders:
    - {c4, s[3:0]} = a_r[4k+3:4k] + b_r[4k+3:4k] + carry_r
    - Write s into the working sum register at [4k+3:4k].
    - carry_r <= c4.
    - k <= k+1.
  - Implementing this as a right-shift of a_r and b_r with the sum shifted in from the top is permitted. The result must be identical.
  - When k=NIB-1 at the edge:
    - Load sum from the completed working register, with the final nibble merged in.
    - cout <= c4.
    - Go to DONE.
- State DONE: busy=0, done=1 for exactly this one cycle.
  - Next edge with start=1: accept a new operation (back-to-back) and go to RUN.
  - Next edge with start=0: go to IDLE.
- Latency: start is sampled at edge E0.
  - Nibbles are processed at edges E1..E_NIB.
  - done is high between E_NIB and E_NIB+1.
  - busy is high from E0 to E_NIB.
  - With WIDTH=16, done appears 4 cycles after the accepting edge. With WIDTH=4, it appears 1 cycle after.
- sum and cout change only on the completion edge or on reset. They hold the last result through IDLE and during a following RUN, until the next completion.
- start is ignored while busy=1. No queuing. a, b and cin may change freely after acceptance.
- Arithmetic is unsigned modulo 2^WIDTH, with the carry reported on cout. cin participates only in nibble 0.
- Reset mid-RUN aborts the operation: no done pulse, and sum and cout go to 0.
- The counter width is sufficient for NIB-1. The count never wraps inside an operation.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, start for one cycle -> busy for 4 cycles, then done pulse of exactly one cycle with sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry propagates through every nibble, giving sum=0x0000, cout=1. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- During RUN of a=0x0001, b=0x0001, pulse start with a=0x7000, b=0x1000 -> the second start is ignored. Result is sum=0x0002, cout=0, exactly one done pulse, and sum holds 0x0002 afterwards.
- Hold start=1 continuously with a new operand pair (0x8000+0x8000, then 0x00FF+0x0001) -> accepted again in the DONE cycle. Results are 0x0000/cout=1, then 0x0100/cout=0, separated by 5 cycles.
- Assert rst_n=0 for one cycle midway through RUN (after 2 nibbles) -> outputs go to 0 immediately, busy=0, no done pulse. A new start afterwards with 0x0F0F+0xF0F0 gives 0xFFFF, cout=0.
- WIDTH=4 instance: a=0x9, b=0x8, cin=1 -> done one cycle after acceptance, sum=0x2, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit unsigned adder: one 4-bit ripple slice per clock, LSB
// nibble first, carry held in a register between nibbles. start/busy/done handshake.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  // Handshake: start is sampled on a rising edge only while busy=0 (IDLE or DONE);
  // done is high for exactly the one cycle after the completion edge.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r, work_r, work_nxt;
  logic             carry_r;
  logic [KW-1:0]    k;
  logic [3:0]       an, bn, s;
  logic [4:0]       c;
  logic             load, last;

  assign last = (k == KW'(NIB - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        load      = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select nibble k, run it through a 4-bit ripple of full adders, merge it back.
  always_comb begin
    an       = '0;
    bn       = '0;
    s        = '0;
    c        = '0;
    work_nxt = work_r;
    for (int i = 0; i < NIB; i++) begin
      if (k == KW'(i)) begin
        an = a_r[4*i +: 4];
        bn = b_r[4*i +: 4];
      end
    end
    c[0] = carry_r;
    for (int j = 0; j < 4; j++) begin
      s[j]   = an[j] ^ bn[j] ^ c[j];
      c[j+1] = (an[j] & bn[j]) | (c[j] & (an[j] ^ bn[j]));
    end
    for (int i = 0; i < NIB; i++) begin
      if (k == KW'(i)) work_nxt[4*i +: 4] = s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      k       <= '0;
      work_r  <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      a_r     <= a;
      b_r     <= b;
      carry_r <= cin;
      k       <= '0;
    end else if (state == RUN) begin
      work_r  <= work_nxt;
      carry_r <= c[4];
      k       <= last ? '0 : k + 1'b1;
      // sum/cout only move on the completion edge; they hold otherwise
      if (last) begin
        sum  <= work_nxt;
        cout <= c[4];
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: WIDTH=16 instance with a result
// scoreboard, plus a WIDTH=4 instance for the single-nibble case.
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout;
  logic [15:0] sum;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4, done4, cout4;
  logic [3:0]  sum4;

  int vec_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  logic [16:0] exp_q[$];

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: each done pulse pops one expected {cout,sum}
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else chk("result", 32'({cout, sum}), 32'(exp_q.pop_front()));
    end
  end

  // driver: start for one cycle; push an expectation only if it will be accepted
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                       input bit accept);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    if (accept) exp_q.push_back({1'b0, ta} + {1'b0, tb_v} + {16'd0, tc});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int cyc;
    int dc;
    logic [15:0] ra, rb;
    logic        rc;

    // reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // basic add, latency 4, one-cycle done
    issue(16'h1234, 16'h4321, 1'b0, 1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("latency16", 32'(cyc), 32'd4);
    chk("busy_in_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_width", 32'(done), 32'd0);
    chk("hold_idle", 32'(sum), 32'h5555);

    // full carry ripple
    issue(16'hFFFF, 16'h0001, 1'b0, 1);
    wait_done(cyc);
    idle_cycles(1);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1);
    wait_done(cyc);
    idle_cycles(1);

    // start during RUN is ignored
    dc = done_cnt;
    issue(16'h0001, 16'h0001, 1'b0, 1);
    idle_cycles(1);
    issue(16'h7000, 16'h1000, 1'b0, 0);
    wait_done(cyc);
    chk("lat_ignored", 32'(cyc), 32'd2);
    idle_cycles(6);
    chk("one_done", 32'(done_cnt - dc), 32'd1);
    chk("hold_after_ignore", 32'(sum), 32'h0002);
    chk("idle_busy", 32'(busy), 32'd0);

    // back-to-back with start held high
    a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
    exp_q.push_back(17'h10000);
    @(posedge clk); #1;
    chk("sum_hold_run", 32'(sum), 32'h0002);
    a = 16'h00FF; b = 16'h0001;
    exp_q.push_back(17'h00100);
    wait_done(cyc);
    chk("b2b_lat1", 32'(cyc), 32'd4);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_rerun", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("b2b_gap", 32'(cyc + 1), 32'd5);
    idle_cycles(2);

    // reset in the middle of RUN
    issue(16'hAAAA, 16'h5555, 1'b0, 1);
    idle_cycles(2);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(6);
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    issue(16'h0F0F, 16'hF0F0, 1'b0, 1);
    wait_done(cyc);
    idle_cycles(1);

    // random operands
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, 1);
      wait_done(cyc);
      chk("latency_rand", 32'(cyc), 32'd4);
      idle_cycles(i % 2);
    end

    // WIDTH=4: single nibble, done one cycle after acceptance
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("w4_busy", 32'(busy4), 32'd1);
    @(posedge clk); #1;
    chk("w4_done", 32'(done4), 32'd1);
    chk("w4_sum",  32'(sum4),  32'h2);
    chk("w4_cout", 32'(cout4), 32'd1);
    @(posedge clk); #1;
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    chk("w4_done2", 32'(done4), 32'd1);
    chk("w4_sum2",  32'({cout4, sum4}), 32'h1F);

    idle_cycles(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
